id_ex_register: RTL

- ID/EX pipeline register of the pipelined MIPS core.
- Captures decoded control (including the 2-bit ALUOp and 4-bit function code consumed by the EX-stage ALU control decoder), register operands, immediate and register specifiers at the end of ID.
- Presents them to EX one cycle later.
- Supports hazard-unit stall (hold), flush (bubble insertion), valid tracking and a stall-watchdog.

---
 rtl/id_ex_register.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall hold, flush bubble, valid tracking and stall watchdog.
// Optional performance counters are enabled by defining ID_EX_PERF_COUNTERS_EN.
module id_ex_register #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STALL_LIMIT    = 15
) (
   input  logic                      i_Clk,
   input  logic                      i_Reset_n,
   input  logic                      i_Stall,
   input  logic                      i_Flush,
   input  logic                      i_Valid,
   input  logic [1:0]                i_ALUOp,
   input  logic [3:0]                i_Function,
   input  logic                      i_RegWrite,
   input  logic                      i_MemRead,
   input  logic                      i_MemWrite,
   input  logic                      i_MemtoReg,
   input  logic                      i_ALUSrc,
   input  logic                      i_RegDst,
   input  logic [DATA_WIDTH-1:0]     i_Read_Data1,
   input  logic [DATA_WIDTH-1:0]     i_Read_Data2,
   input  logic [DATA_WIDTH-1:0]     i_Imm,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rs,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rt,
   input  logic [REG_ADDR_WIDTH-1:0] i_Rd,
   output logic [1:0]                o_ALUOp,
   output logic [3:0]                o_Function,
   output logic                      o_RegWrite,
   output logic                      o_MemRead,
   output logic                      o_MemWrite,
   output logic                      o_MemtoReg,
   output logic                      o_ALUSrc,
   output logic                      o_RegDst,
   output logic [DATA_WIDTH-1:0]     o_Read_Data1,
   output logic [DATA_WIDTH-1:0]     o_Read_Data2,
   output logic [DATA_WIDTH-1:0]     o_Imm,
   output logic [REG_ADDR_WIDTH-1:0] o_Rs,
   output logic [REG_ADDR_WIDTH-1:0] o_Rt,
   output logic [REG_ADDR_WIDTH-1:0] o_Rd,
   output logic                      o_Valid,
   output logic                      o_Stall_Timeout
`ifdef ID_EX_PERF_COUNTERS_EN
   ,output logic [31:0]              o_Bubble_Count,
   output logic [31:0]               o_Stall_Count
`endif
);

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   logic [1:0]                alu_op_q, alu_op_d;
   logic [3:0]                func_q, func_d;
   logic [5:0]                ctl_q, ctl_d;   // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst}
   logic [DATA_WIDTH-1:0]     rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
   logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic                      valid_q, valid_d;
   logic [7:0]                stall_cnt_q, stall_cnt_d;
   logic                      timeout_q, timeout_d;
`ifdef ID_EX_PERF_COUNTERS_EN
   logic [31:0]               bubble_cnt_q, bubble_cnt_d, stall_tot_q, stall_tot_d;
`endif

   always_comb begin
      alu_op_d    = alu_op_q;
      func_d      = func_q;
      ctl_d       = ctl_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      imm_d       = imm_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      valid_d     = valid_q;
      stall_cnt_d = 8'd0;
`ifdef ID_EX_PERF_COUNTERS_EN
      bubble_cnt_d = bubble_cnt_q;
      stall_tot_d  = stall_tot_q;
`endif
      if (i_Flush) begin
         alu_op_d = '0;
         func_d   = '0;
         ctl_d    = '0;
         rd1_d    = '0;
         rd2_d    = '0;
         imm_d    = '0;
         rs_d     = '0;
         rt_d     = '0;
         rd_d     = '0;
         valid_d  = 1'b0;
`ifdef ID_EX_PERF_COUNTERS_EN
         bubble_cnt_d = bubble_cnt_q + 32'd1;
`endif
      end else if (i_Stall) begin
         stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
`ifdef ID_EX_PERF_COUNTERS_EN
         stall_tot_d = stall_tot_q + 32'd1;
`endif
      end else begin
         alu_op_d = i_ALUOp;
         func_d   = i_Function;
         // Invalid slots must never reach a state-writing stage with write enables set.
         ctl_d    = {i_RegWrite & i_Valid, i_MemRead & i_Valid, i_MemWrite & i_Valid,
                     i_MemtoReg, i_ALUSrc, i_RegDst};
         rd1_d    = i_Read_Data1;
         rd2_d    = i_Read_Data2;
         imm_d    = i_Imm;
         rs_d     = i_Rs;
         rt_d     = i_Rt;
         rd_d     = i_Rd;
         valid_d  = i_Valid;
`ifdef ID_EX_PERF_COUNTERS_EN
         if (!i_Valid) bubble_cnt_d = bubble_cnt_q + 32'd1;
`endif
      end
      timeout_d = (stall_cnt_d >= LIMIT);
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         alu_op_q    <= '0;
         func_q      <= '0;
         ctl_q       <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= 8'd0;
         timeout_q   <= 1'b0;
`ifdef ID_EX_PERF_COUNTERS_EN
         bubble_cnt_q <= 32'd0;
         stall_tot_q  <= 32'd0;
`endif
      end else begin
         alu_op_q    <= alu_op_d;
         func_q      <= func_d;
         ctl_q       <= ctl_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
`ifdef ID_EX_PERF_COUNTERS_EN
         bubble_cnt_q <= bubble_cnt_d;
         stall_tot_q  <= stall_tot_d;
`endif
      end
   end

   assign o_ALUOp         = alu_op_q;
   assign o_Function      = func_q;
   assign {o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUSrc, o_RegDst} = ctl_q;
   assign o_Read_Data1    = rd1_q;
   assign o_Read_Data2    = rd2_q;
   assign o_Imm           = imm_q;
   assign o_Rs            = rs_q;
   assign o_Rt            = rt_q;
   assign o_Rd            = rd_q;
   assign o_Valid         = valid_q;
   assign o_Stall_Timeout = timeout_q;
`ifdef ID_EX_PERF_COUNTERS_EN
   assign o_Bubble_Count  = bubble_cnt_q;
   assign o_Stall_Count   = stall_tot_q;
`endif

endmodule
